// File: rtl/uart_pkg.sv
// Shared state encodings and line constants for the FIFO-draining UART transmitter.
package uart_pkg;

  localparam logic [2:0] IDLE_ENC  = 3'd0;
  localparam logic [2:0] FETCH_ENC = 3'd1;
  localparam logic [2:0] LOAD_ENC  = 3'd2;
  localparam logic [2:0] START_ENC = 3'd3;
  localparam logic [2:0] DATA_ENC  = 3'd4;
  localparam logic [2:0] STOP_ENC  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = IDLE_ENC,
    FETCH = FETCH_ENC,
    LOAD  = LOAD_ENC,
    START = START_ENC,
    DATA  = DATA_ENC,
    STOP  = STOP_ENC
  } uart_state_e;

  localparam int   DEFAULT_CLKS_PER_BIT = 868;
  localparam logic LINE_IDLE            = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Pop handshake between the transmit FIFO and the UART transmitter.
interface uart_tx_fifo_drain_if #(
  parameter int WIDTH = 8
);

  logic             fifo_rd;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;

  modport master (output fifo_rd, input fifo_empty, input fifo_data);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_data);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic          bit_end,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  logic [CW-1:0] count_r;

  // Period counter; clear wins so every state starts its first bit at zero.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO;
    end else if (clear) begin
      count_r <= ZERO;
    end else if (enable) begin
      if (count_r == LAST) begin
        count_r <= ZERO;
      end else begin
        count_r <= count_r + ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign bit_end = enable && (count_r == LAST);
  assign count   = count_r;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1-style transmitter that pops bytes from the transmit FIFO and shifts them out LSB first.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 EN,
  uart_tx_fifo_drain_if.master fifo,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  if (STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2) begin : g_bad_params
    $error("uart_tx_fifo_drain: STOP_BITS must be 1..2 and CLKS_PER_BIT at least 2");
  end

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [CW-1:0] PRE_LAST  = CW'(CLKS_PER_BIT - 2);

  uart_state_e      state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
  logic             tx_r, tx_s;
  logic             busy_r, done_r, done_s, rd_r;
  logic             bit_end_s, baud_en_s, baud_clr_s;
  logic [CW-1:0]    baud_cnt_s;

  assign baud_en_s  = (state_r == START) || (state_r == DATA) || (state_r == STOP);
  assign baud_clr_s = (state_s != state_r);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (baud_clr_s),
    .enable  (baud_en_s),
    .bit_end (bit_end_s),
    .count   (baud_cnt_s)
  );

  // Next-state, shift register, bit counter and next line level.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    done_s    = 1'b0;
    tx_s      = LINE_IDLE;
    case (state_r)
      IDLE: begin
        if (EN && !fifo.fifo_empty) state_s = FETCH;
        else                        state_s = IDLE;
      end
      FETCH: state_s = LOAD;
      LOAD: begin
        shift_s = fifo.fifo_data;
        state_s = START;
      end
      START: begin
        if (bit_end_s) state_s = DATA;
        else           state_s = START;
      end
      DATA: begin
        if (bit_end_s) begin
          if (bit_cnt_r == LAST_DATA) begin
            state_s = STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
            shift_s   = {1'b0, shift_r[WIDTH-1:1]};
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        // tx_done is registered, so arm it one cycle before the final stop cycle.
        done_s = (bit_cnt_r == LAST_STOP) && (baud_cnt_s == PRE_LAST);
        if (bit_end_s) begin
          if (bit_cnt_r == LAST_STOP) begin
            if (EN && !fifo.fifo_empty) state_s = FETCH;
            else                        state_s = IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase

    if (state_s != state_r) bit_cnt_s = BIT_ZERO;
    else                    bit_cnt_s = bit_cnt_s;

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      default: tx_s = LINE_IDLE;
    endcase
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shift_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= BIT_ZERO;
      tx_r      <= LINE_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      tx_r      <= tx_s;
      busy_r    <= (state_s != IDLE);
      done_r    <= done_s;
      rd_r      <= (state_s == FETCH);
    end
  end

  assign tx           = tx_r;
  assign busy         = busy_r;
  assign tx_done      = done_r;
  assign fifo.fifo_rd = rd_r;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: three transmitter instances (C=4/W=8, C=868/S=2, C=4/W=7) fed by queue FIFO models.
module tb_uart_tx_fifo_drain;

  localparam int N = 3;

  logic         sys_clk = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] en_v;
  logic [N-1:0] tx_v, busy_v, done_v, rd_v;
  logic [7:0]   fq [N][$];
  logic [7:0]   exp_q [$];
  logic [7:0]   b2b [3] = '{8'h00, 8'hFF, 8'h3C};
  int           checks   = 0;
  int           failures = 0;

  logic [7:0] r_byte;
  int         r_gap, r_len, r_stop, base_rd, base_done;
  bit         r_hold, r_ok, low_seen, found;

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 2) ? 7 : 8;
    localparam int C = (g == 1) ? 868 : 4;
    localparam int S = (g == 1) ? 2 : 1;

    uart_tx_fifo_drain_if #(.WIDTH(W)) fifo_if ();

    logic [W-1:0] data_r   = {W{1'b0}};
    logic         empty_r  = 1'b1;
    int           rd_cnt   = 0;
    int           done_cnt = 0;

    assign fifo_if.fifo_empty = empty_r;
    assign fifo_if.fifo_data  = data_r;
    assign rd_v[g]            = fifo_if.fifo_rd;

    uart_tx_fifo_drain #(.WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(S)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .EN      (en_v[g]),
      .fifo    (fifo_if),
      .tx      (tx_v[g]),
      .busy    (busy_v[g]),
      .tx_done (done_v[g])
    );

    // FIFO model: registered data_o on rd, EMPTY follows queue depth one edge later.
    always @(posedge sys_clk) begin
      if (fifo_if.fifo_rd) begin
        rd_cnt <= rd_cnt + 1;
        check_eq("rd_nonempty", (fq[g].size() != 0), 1);
        if (fq[g].size() != 0) data_r <= W'(fq[g].pop_front());
      end
      if (done_v[g]) done_cnt <= done_cnt + 1;
      empty_r <= (fq[g].size() == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic score(input string tag, input logic [7:0] got);
    logic [7:0] want;
    if (exp_q.size() != 0) want = exp_q.pop_front();
    else                   want = 8'hxx;
    check_eq(tag, got, want);
  endtask

  // Wait for a start bit, then sample every cycle until tx_done; gap counts idle-high cycles before it.
  task automatic rx_frame(input int g, input int w, input int c, input int budget,
                          output logic [7:0] data_o, output int gap, output int flen,
                          output int slen, output bit hold_ok, output bit got_ok);
    int   k, run;
    logic lvl;
    bit   in_frame;
    data_o = 8'h00; gap = 0; flen = 0; slen = 0; hold_ok = 1'b1; got_ok = 1'b0;
    in_frame = 1'b0; k = 0; run = 0; lvl = 1'b1;
    for (int i = 0; i < budget && !got_ok; i++) begin
      @(negedge sys_clk);
      if (!in_frame) begin
        if (tx_v[g] == 1'b0) in_frame = 1'b1;
        else                 gap++;
      end
      if (in_frame) begin
        if (k % c == 0)           lvl = tx_v[g];
        else if (tx_v[g] !== lvl) hold_ok = 1'b0;
        if (k % c == 0 && k / c >= 1 && k / c <= w) data_o[k / c - 1] = tx_v[g];
        run = (tx_v[g] == 1'b1) ? run + 1 : 0;
        if (done_v[g] == 1'b1) begin
          got_ok = 1'b1;
          flen   = k + 1;
          slen   = run;
        end
        k++;
      end
    end
  endtask

  initial begin
    en_v = 3'b111;
    fq[0].push_back(8'hA5);
    exp_q.push_back(8'hA5);
    repeat (4) @(negedge sys_clk);
    check_eq("rst_tx", tx_v[0], 1);
    check_eq("rst_busy", busy_v[0], 0);
    check_eq("rst_done", done_v[0], 0);
    check_eq("rst_rd", rd_v[0], 0);
    rst_n = 1'b1;

    rx_frame(0, 8, 4, 200, r_byte, r_gap, r_len, r_stop, r_hold, r_ok);
    check_eq("single_ok", r_ok, 1);
    score("single_byte", r_byte);
    check_eq("single_len", r_len, 40);
    check_eq("single_hold", r_hold, 1);
    @(negedge sys_clk);
    check_eq("single_busy_drop", busy_v[0], 0);
    check_eq("single_rd_cnt", g_dut[0].rd_cnt, 1);
    check_eq("single_done_cnt", g_dut[0].done_cnt, 1);

    base_rd = g_dut[0].rd_cnt;
    base_done = g_dut[0].done_cnt;
    for (int i = 0; i < 3; i++) begin
      fq[0].push_back(b2b[i]);
      exp_q.push_back(b2b[i]);
    end
    for (int i = 0; i < 3; i++) begin
      rx_frame(0, 8, 4, 300, r_byte, r_gap, r_len, r_stop, r_hold, r_ok);
      check_eq("b2b_ok", r_ok, 1);
      score("b2b_byte", r_byte);
      check_eq("b2b_len", r_len, 40);
      check_eq("b2b_hold", r_hold, 1);
      if (i > 0) check_eq("b2b_gap", r_gap, 2);
    end
    repeat (10) @(negedge sys_clk);
    check_eq("b2b_rd_cnt", g_dut[0].rd_cnt - base_rd, 3);
    check_eq("b2b_done_cnt", g_dut[0].done_cnt - base_done, 3);

    base_rd = g_dut[0].rd_cnt;
    low_seen = 1'b0;
    repeat (100) begin
      @(negedge sys_clk);
      if (tx_v[0] == 1'b0) low_seen = 1'b1;
    end
    check_eq("empty_rd", g_dut[0].rd_cnt - base_rd, 0);
    check_eq("empty_tx_low", low_seen, 0);

    en_v[0] = 1'b0;
    fq[0].push_back(8'h5A);
    repeat (50) @(negedge sys_clk);
    check_eq("en_off_rd", g_dut[0].rd_cnt - base_rd, 0);
    check_eq("en_off_busy", busy_v[0], 0);
    exp_q.push_back(8'h5A);
    en_v[0] = 1'b1;
    rx_frame(0, 8, 4, 200, r_byte, r_gap, r_len, r_stop, r_hold, r_ok);
    check_eq("en_on_ok", r_ok, 1);
    score("en_on_byte", r_byte);

    base_rd = g_dut[0].rd_cnt;
    fq[0].push_back(8'hC3);
    fq[0].push_back(8'h96);
    exp_q.push_back(8'hC3);
    fork
      rx_frame(0, 8, 4, 200, r_byte, r_gap, r_len, r_stop, r_hold, r_ok);
      begin
        repeat (15) @(negedge sys_clk);
        en_v[0] = 1'b0;
      end
    join
    check_eq("en_drop_ok", r_ok, 1);
    score("en_drop_byte", r_byte);
    check_eq("en_drop_len", r_len, 40);
    repeat (60) @(negedge sys_clk);
    check_eq("en_drop_rd", g_dut[0].rd_cnt - base_rd, 1);
    check_eq("en_drop_busy", busy_v[0], 0);

    // 0x96 is popped and then lost to reset; 0x6D must follow cleanly.
    base_rd = g_dut[0].rd_cnt;
    fq[0].push_back(8'h6D);
    exp_q.push_back(8'h6D);
    en_v[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge sys_clk);
      if (tx_v[0] == 1'b0) found = 1'b1;
    end
    check_eq("rst_mid_start", found, 1);
    repeat (17) @(negedge sys_clk);
    check_eq("rst_mid_bit3", tx_v[0], 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx", tx_v[0], 1);
    check_eq("rst_mid_busy", busy_v[0], 0);
    check_eq("rst_mid_rd", rd_v[0], 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    rx_frame(0, 8, 4, 200, r_byte, r_gap, r_len, r_stop, r_hold, r_ok);
    check_eq("rst_next_ok", r_ok, 1);
    score("rst_next_byte", r_byte);
    check_eq("rst_next_len", r_len, 40);
    repeat (10) @(negedge sys_clk);
    check_eq("rst_rd_cnt", g_dut[0].rd_cnt - base_rd, 2);
    check_eq("rst_fifo_left", fq[0].size(), 0);

    fq[1].push_back(8'h55);
    exp_q.push_back(8'h55);
    rx_frame(1, 8, 868, 12000, r_byte, r_gap, r_len, r_stop, r_hold, r_ok);
    check_eq("stop2_ok", r_ok, 1);
    score("stop2_byte", r_byte);
    check_eq("stop2_len", r_len, 9548);
    check_eq("stop2_stop_len", r_stop, 1736);
    check_eq("stop2_hold", r_hold, 1);

    fq[2].push_back(8'h2B);
    exp_q.push_back(8'h2B);
    rx_frame(2, 7, 4, 200, r_byte, r_gap, r_len, r_stop, r_hold, r_ok);
    check_eq("w7_ok", r_ok, 1);
    score("w7_byte", r_byte);
    check_eq("w7_len", r_len, 36);
    check_eq("w7_stop_len", r_stop, 4);
    check_eq("w7_hold", r_hold, 1);
    @(negedge sys_clk);
    check_eq("w7_rd_cnt", g_dut[2].rd_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
